// File: rtl/tx_frame_pkg.sv
// Shared constants for the Modbus RTU transmit path: CRC-16 parameters and
// frame-controller state encodings.
package tx_frame_pkg;

    localparam logic [15:0] CRC_POLY = 16'hA001;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CRC     = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;
    localparam logic [2:0] ST_SILENCE = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

endpackage

// File: rtl/modbus_crc16_bit.sv
// Combinational single-bit Modbus CRC-16 update (reflected, LSB-first).
// Feeding a byte's bits LSB-first is equivalent to XORing the byte in first.
module modbus_crc16_bit
    import tx_frame_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic        data_bit,
    output logic [15:0] crc_out
);

    logic feedback;

    assign feedback = crc_in[0] ^ data_bit;
    assign crc_out  = {1'b0, crc_in[15:1]} ^ (feedback ? CRC_POLY : 16'h0000);

endmodule

// File: rtl/tx_frame_ctrl.sv
// Transmit frame controller: latches a payload, computes its Modbus CRC bit-serially,
// hands payload+CRC bytes to the UART TX over enable/done, then enforces line silence.
module tx_frame_ctrl
    import tx_frame_pkg::*;
#(
    parameter int PAYLOAD_BYTES  = 5,
    parameter int SILENCE_CYCLES = 3645,
    parameter int CNT_W          = 12
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       Frame_Start_Sig,
    input  logic [8*PAYLOAD_BYTES-1:0] Frame_Data,
    input  logic                       TX_Done_Sig,
    output logic                       TX_En_Sig,
    output logic [7:0]                 TX_Data,
    output logic                       Busy_Sig,
    output logic                       Frame_Done_Sig
);

    localparam int                IDX_W        = $clog2(PAYLOAD_BYTES + 2);
    localparam logic [IDX_W-1:0]  LAST_PAYLOAD = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [IDX_W-1:0]  CRC_LO_IDX   = IDX_W'(PAYLOAD_BYTES);
    localparam logic [IDX_W-1:0]  LAST_BYTE    = IDX_W'(PAYLOAD_BYTES + 1);
    localparam logic [CNT_W-1:0]  SIL_LAST     = (SILENCE_CYCLES > 0) ? CNT_W'(SILENCE_CYCLES - 1) : '0;

    logic [2:0]                 state;
    logic [8*PAYLOAD_BYTES-1:0] payload_q;
    logic [15:0]                crc_q;
    logic [15:0]                crc_next;
    logic [IDX_W-1:0]           idx;
    logic [2:0]                 bit_cnt;
    logic [CNT_W-1:0]           sil_cnt;
    logic [7:0]                 cur_byte;
    logic [7:0]                 frame_byte;
    logic                       accept;

    assign accept         = (state == ST_IDLE) && Frame_Start_Sig;
    assign TX_En_Sig      = (state == ST_SEND);
    assign Busy_Sig       = (state != ST_IDLE);
    assign Frame_Done_Sig = (state == ST_DONE);

    // NOTE: pure datapath capture with no reset; it is always written on accept before being read.
    always_ff @(posedge CLK) begin
        if (accept) begin
            payload_q <= Frame_Data;
        end
    end

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_byte = payload_q[i*8 +: 8];
            end
        end
    end

    always_comb begin
        frame_byte = cur_byte;
        if (idx == CRC_LO_IDX) begin
            frame_byte = crc_q[7:0];
        end else if (idx == LAST_BYTE) begin
            frame_byte = crc_q[15:8];
        end
    end

    modbus_crc16_bit u_crc_bit (
        .crc_in   (crc_q),
        .data_bit (cur_byte[bit_cnt]),
        .crc_out  (crc_next)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= ST_IDLE;
            crc_q   <= CRC_INIT;
            idx     <= '0;
            bit_cnt <= '0;
            sil_cnt <= '0;
            TX_Data <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Frame_Start_Sig) begin
                        crc_q   <= CRC_INIT;
                        idx     <= '0;
                        bit_cnt <= '0;
                        state   <= ST_CRC;
                    end
                end
                ST_CRC: begin
                    crc_q   <= crc_next;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (idx == LAST_PAYLOAD) begin
                            idx   <= '0;
                            state <= ST_LOAD;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    TX_Data <= frame_byte;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (TX_Done_Sig) begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    sil_cnt <= '0;
                    if (idx == LAST_BYTE) begin
                        idx   <= '0;
                        // A zero gap skips SILENCE so DONE still lands one cycle after GAP.
                        state <= (SILENCE_CYCLES == 0) ? ST_DONE : ST_SILENCE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= ST_LOAD;
                    end
                end
                ST_SILENCE: begin
                    sil_cnt <= sil_cnt + CNT_W'(1);
                    if (sil_cnt == SIL_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tx_frame_ctrl.md
Name: tx_frame_ctrl

Overview:
Transmit-side frame controller for the Modbus link: the outbound counterpart of the receive-side byte capture stage.
- Latches a payload of PAYLOAD_BYTES bytes on a start request.
- Computes the Modbus RTU CRC-16 over the payload.
- Feeds payload then CRC (low byte first) one byte at a time to the UART TX module over its enable/done handshake.
- Enforces inter-frame silence, then reports completion.
- Default: 5 payload bytes + 2 CRC bytes = 7-byte frame.

Parameters:
PAYLOAD_BYTES, 5, payload byte count; range 1..16; frame length = PAYLOAD_BYTES+2
SILENCE_CYCLES, 3645, post-frame idle clocks before Frame_Done_Sig (3.5 chars at 9600 baud / 1 MHz-equivalent); 0 = no gap
CNT_W, 12, width of silence counter; must hold SILENCE_CYCLES

Ports:
CLK  input  1  system clock, rising edge
RSTn  input  1  asynchronous active-low reset
Frame_Start_Sig  input  1  one-cycle start request; ignored while Busy_Sig=1
Frame_Data  input  8*PAYLOAD_BYTES  payload; byte 0 = [7:0] is sent first; sampled only on an accepted start
TX_Done_Sig  input  1  one-cycle pulse from UART TX: current byte fully shifted out
TX_En_Sig  output  1  level request to UART TX; held high until TX_Done_Sig
TX_Data  output  8  byte to transmit; stable whenever TX_En_Sig=1
Busy_Sig  output  1  high from accept through the Frame_Done_Sig cycle
Frame_Done_Sig  output  1  one-cycle pulse: frame sent and silence elapsed

Behaviour:
- Reset (async, RSTn=0): TX_En_Sig=0, TX_Data=8'h00, Busy_Sig=0, Frame_Done_Sig=0, state=IDLE, CRC register=16'hFFFF, indices=0.
- IDLE
  - Frame_Start_Sig=1 in cycle T: latch Frame_Data, set CRC=16'hFFFF, byte index=0, bit count=0, go to CRC.
  - Busy_Sig=1 from T+1.
- CRC
  - One bit per cycle, 8 cycles per byte, 8*PAYLOAD_BYTES cycles in total.
  - Per byte: crc ^= {8'h00, byte}.
  - Per bit: if crc[0], crc = (crc>>1) ^ 16'hA001; else crc = crc>>1.
  - Then go to LOAD.
- LOAD
  - TX_Data = frame byte[idx], where idx 0..PAYLOAD_BYTES-1 = payload, idx PAYLOAD_BYTES = crc[7:0], idx PAYLOAD_BYTES+1 = crc[15:8].
  - TX_En_Sig=1 from the next cycle; go to SEND.
  - First TX_En_Sig rise occurs at T+1+8*PAYLOAD_BYTES+1.
- SEND
  - Hold TX_En_Sig=1 and TX_Data stable until TX_Done_Sig=1 is sampled.
  - Then TX_En_Sig=0 for at least one cycle (GAP state).
- GAP
  - idx++.
  - If idx == PAYLOAD_BYTES+2, go to SILENCE; else go to LOAD.
  - Each byte therefore has ≥1 cycle of TX_En_Sig low between requests.
- SILENCE
  - Count SILENCE_CYCLES clocks with TX_En_Sig=0, then go to DONE. SILENCE_CYCLES=0 goes to DONE immediately.
- DONE
  - Frame_Done_Sig=1 for exactly one cycle, Busy_Sig still 1; next cycle IDLE, Busy_Sig=0.
- Boundary rules
  - Frame_Start_Sig while Busy_Sig=1 is dropped; there is no queueing.
  - Frame_Start_Sig in the same cycle as Frame_Done_Sig is dropped. A start is first accepted in the cycle after DONE.
  - TX_Done_Sig outside SEND is ignored.
  - TX_Done_Sig arriving in the very first SEND cycle is valid.
  - Frame_Data changes after accept have no effect on the frame in flight.
  - RSTn low mid-frame: TX_En_Sig drops immediately (async); the partial frame is abandoned and no Frame_Done_Sig is issued.
  - CRC arithmetic is 16-bit unsigned, wrap-free. Byte index counter width = clog2(PAYLOAD_BYTES+2).

Decomposition:
- Shared package/header, tx_frame_pkg:
  - CRC_POLY=16'hA001, CRC_INIT=16'hFFFF
  - state encodings IDLE, CRC, LOAD, SEND, GAP, SILENCE, DONE (3-bit)
- One sub-module, modbus_crc16_bit: combinational single-bit CRC update.
  - Inputs: crc_in[15:0], data_bit; output: crc_out[15:0].
  - Reusable by the receive-side frame checker.
  - Top keeps the CRC register and sequencing.

Test Plan:
- PAYLOAD_BYTES=6, Frame_Data bytes 01 03 00 00 00 01, UART model returns TX_Done_Sig 20 cycles after each TX_En_Sig rise -> TX_Data sequence 01 03 00 00 00 01 84 0A, then Frame_Done_Sig exactly SILENCE_CYCLES+1 cycles after the last GAP, single cycle.
- PAYLOAD_BYTES=3, bytes 01 83 02 -> sequence 01 83 02 C0 F1; first TX_En_Sig rise at accept+26 cycles.
- Default config, random payloads (1000 frames) vs software CRC-16/Modbus model -> 7 bytes per frame, CRC bytes match; TX_Data never changes while TX_En_Sig=1; TX_En_Sig low ≥1 cycle between bytes.
- Frame_Start_Sig pulsed mid-frame and in the Frame_Done_Sig cycle -> both ignored, in-flight bytes unchanged, no second frame; start one cycle later is accepted.
- Spurious TX_Done_Sig in IDLE/CRC/SILENCE, plus TX_Done_Sig in the first SEND cycle -> no byte skipped or repeated, all 7 bytes emitted once.
- RSTn asserted while sending byte 3 -> TX_En_Sig=0 and Busy_Sig=0 without a clock edge, no Frame_Done_Sig; a new start after release sends a full, correct frame.
